seven_seg_scanner: RTL and testbench

- Time-multiplexed driver for the board's 8-digit seven-segment display; produces the out7/en_out pair that Top drives to the pins.
- Accepts a 32-bit value from the datapath (e.g. PC or a debug register) through a valid/ready handshake.
- Double-buffers the value so a new word is only shown from a frame boundary, so no digit shows half-old, half-new data.
- Scans one hex nibble per digit at a programmable refresh rate.

---
 rtl/seg_pkg.sv | 26 ++
 rtl/hex_to_7seg.sv | 32 +++
 rtl/seven_seg_scanner.sv | 96 +++++++++
 tb/tb_seven_seg_scanner.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: active-low {g..a} segment
// patterns for hex digits, blank codes and the digit count.
package seg_pkg;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [7:0] EN_OFF     = 8'hFF;
  localparam int         NUM_DIGITS = 8;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational 4-bit to active-low seven-segment ({g,f,e,d,c,b,a}) decoder.
module hex_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 8-digit hex display driver with a double-buffered word input.
// Define SEG_LZ_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value_in,
  input  logic        value_valid,
  output logic        value_ready,
  output logic [6:0]  out7,
  output logic [7:0]  en_out,
  output logic        frame_done
);
  import seg_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_p0;
  logic [2:0]       idx_p0;
  logic [31:0]      display;
  logic [31:0]      pending;
  logic             pending_full;
  logic             tick;
  logic             wrap;
  logic             xfer;
  logic [3:0]       nibble;
  logic [6:0]       seg;
  logic             blank;

  assign tick        = (cnt_p0 == CNT_LAST);
  assign wrap        = tick && (idx_p0 == IDX_LAST);
  // The wrap cycle frees the pending slot, so a producer can refill it at once.
  assign value_ready = !pending_full || wrap;
  assign xfer        = value_valid && value_ready;
  assign nibble      = display[{idx_p0, 2'b00} +: 4];

  hex_to_7seg u_dec (
    .nibble (nibble),
    .seg    (seg)
  );

`ifdef SEG_LZ_BLANK_EN
  assign blank = (idx_p0 != 3'd0) && ((display >> {idx_p0, 2'b00}) == 32'd0);
`else
  assign blank = 1'b0;
`endif

  // ---- stage p0: prescaler and digit index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_p0 <= '0;
      idx_p0 <= 3'd0;
    end else if (tick) begin
      cnt_p0 <= '0;
      idx_p0 <= idx_p0 + 3'd1;
    end else begin
      cnt_p0 <= cnt_p0 + 1'b1;
    end
  end

  // Pending word is committed only at a frame boundary; a same-cycle transfer
  // refills pending after the old contents have moved to display.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      display      <= 32'd0;
      pending      <= 32'd0;
      pending_full <= 1'b0;
    end else begin
      if (wrap && pending_full)
        display <= pending;
      if (xfer) begin
        pending      <= value_in;
        pending_full <= 1'b1;
      end else if (wrap) begin
        pending_full <= 1'b0;
      end
    end
  end

  // ---- stage p1: registered pin drive, one cycle behind the index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out7       <= SEG_OFF;
      en_out     <= EN_OFF;
      frame_done <= 1'b0;
    end else begin
      en_out     <= ~(8'b1 << idx_p0);
      out7       <= blank ? SEG_OFF : seg;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (REFRESH_DIV=4) against a cycle-count
// based reference model of the scan, buffering and handshake rules.
module tb_seven_seg_scanner;

  localparam int DIV = 4;
  localparam int CW  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] value_in = 32'd0;
  logic        value_valid = 1'b0;
  logic        value_ready;
  logic [6:0]  out7;
  logic [7:0]  en_out;
  logic        frame_done;

  always #5 clk = ~clk;

  seven_seg_scanner #(.REFRESH_DIV(DIV), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .value_in    (value_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .out7        (out7),
    .en_out      (en_out),
    .frame_done  (frame_done)
  );

  int asserts = 0;
  int fails   = 0;

  logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference state: cycles since reset release plus the two buffered words.
  int          n;
  logic [31:0] m_disp;
  logic [31:0] m_pend;
  logic        m_full;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int cur_idx();
    return (n / DIV) % 8;
  endfunction

  function automatic bit cur_wrap();
    return ((n % DIV) == DIV - 1) && (cur_idx() == 7);
  endfunction

  function automatic bit model_ready();
    return !m_full || cur_wrap();
  endfunction

  function automatic logic [6:0] model_seg(int k);
    logic [3:0] nib;
    nib = m_disp[4*k +: 4];
`ifdef SEG_LZ_BLANK_EN
    if (k != 0 && (m_disp >> (4*k)) == 32'd0) return 7'h7F;
`endif
    return lut[nib];
  endfunction

  task automatic model_reset();
    n      = 0;
    m_disp = 32'd0;
    m_pend = 32'd0;
    m_full = 1'b0;
  endtask

  task automatic reset_checks();
    check("rst_out7", {25'd0, out7}, 32'h7F);
    check("rst_en_out", {24'd0, en_out}, 32'hFF);
    check("rst_ready", {31'd0, value_ready}, 32'd1);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
  endtask

  // One clock: starts and ends at a falling edge.
  task automatic cycle(bit v, logic [31:0] val);
    int         k;
    bit         w;
    bit         rdy;
    logic [7:0] exp_en;
    logic [6:0] exp_seg;
    value_valid = v;
    value_in    = val;
    #1;
    rdy = model_ready();
    check("value_ready", {31'd0, value_ready}, {31'd0, rdy});
    @(posedge clk);
    k       = cur_idx();
    w       = cur_wrap();
    exp_en  = ~(8'b1 << k);
    exp_seg = model_seg(k);
    if (w && m_full) begin
      m_disp = m_pend;
      m_full = 1'b0;
    end
    if (v && rdy) begin
      m_pend = val;
      m_full = 1'b1;
    end
    n++;
    #1;
    check("en_out", {24'd0, en_out}, {24'd0, exp_en});
    check("out7", {25'd0, out7}, {25'd0, exp_seg});
    check("frame_done", {31'd0, frame_done}, {31'd0, w});
    @(negedge clk);
  endtask

  initial begin
    int          fdc;
    bit          v;
    bit          last_v;
    bit          last_rdy;
    logic [31:0] d;
    bit          found;

    // 1: reset held low for three cycles
    model_reset();
    #1 reset = 1'b0;
    #1 reset_checks();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      reset_checks();
    end
    reset = 1'b1;

    // 2: idle scan, frame_done once per 32 cycles
    fdc = 0;
    for (int i = 0; i < 64; i++) begin
      cycle(1'b0, 32'd0);
      fdc += int'(frame_done);
    end
    check("frame_done_count", fdc, 32'd2);

    // 3: mid-frame accept
    for (int i = 0; i < 10; i++) cycle(1'b0, 32'd0);
    cycle(1'b1, 32'h1234_ABCD);
    for (int i = 0; i < 80; i++) cycle(1'b0, 32'd0);

    // 4: second word then valid held with all-ones while pending is full
    cycle(1'b1, 32'hCAFE_0001);
    for (int i = 0; i < 80; i++) cycle(1'b1, 32'hFFFF_FFFF);
    for (int i = 0; i < 40; i++) cycle(1'b0, 32'd0);

    // 5: asynchronous reset during digit 5 with a word pending
    cycle(1'b1, 32'h600D_F00D);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (cur_idx() == 5 && m_full) found = 1'b1;
      else cycle(1'b0, 32'd0);
    end
    check("reach_digit5_pending", {31'd0, found}, 32'd1);
    #2 reset = 1'b0;
    #1 reset_checks();
    model_reset();
    @(negedge clk);
    reset_checks();
    reset = 1'b1;
    for (int i = 0; i < 70; i++) cycle(1'b0, 32'd0);

    // 6: blanking-shaped words, then random traffic obeying the hold rule
    cycle(1'b1, 32'h0000_00A5);
    for (int i = 0; i < 70; i++) cycle(1'b0, 32'd0);
    cycle(1'b1, 32'h0000_0000);
    for (int i = 0; i < 70; i++) cycle(1'b0, 32'd0);

    last_v = 1'b0;
    last_rdy = 1'b1;
    d = 32'd0;
    for (int i = 0; i < 300; i++) begin
      if (!(last_v && !last_rdy)) begin
        v = ($urandom_range(0, 3) == 0);
        case ($urandom_range(0, 3))
          0: d = 32'h0000_00A5;
          1: d = $urandom & 32'h0000_0FFF;
          2: d = 32'd0;
          default: d = $urandom;
        endcase
      end
      last_rdy = model_ready();
      last_v   = v;
      cycle(v, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
